// File: rtl/uart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_pkg
// Description : Shared constants for the memory-mapped UART bus port:
//               register addresses, CON bit positions, FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bus_pkg;

  // Register map (full 32-bit byte addresses on the CPU data bus)
  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  // CON register bit positions
  localparam int CON_TX_IE     = 0;
  localparam int CON_RX_IE     = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_AVAIL  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_RX_OVR    = 5;
  localparam int CON_FRAME_ERR = 6;
  localparam int CON_W         = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Small synchronous FIFO for received bytes. A push into a full
//               FIFO is dropped unless a pop happens in the same cycle, in
//               which case both are performed. Pops on empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 4,   // power of 2, at least 2
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,   // synchronous, active-low
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_bus_port.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_port
// Description : Memory-mapped 8N1 UART on the CPU data bus. TXD write starts
//               a frame, RXD read pops the receive FIFO, CON holds interrupt
//               enables and status. Contains the baud tick divider and the
//               TX/RX state machines.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_port
  import uart_bus_pkg::*;
#(
  parameter int CLK_HZ   = 10_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,     // synchronous, active-low
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int DIV    = CLK_HZ / (BAUD * OVS);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OVS_W  = $clog2(OVS);

  // ---------------------------------------------------------------- tick
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_W'(DIV - 1));

  // Free-running oversampling tick divider.
  always_ff @(posedge clk) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- bus decode
  logic w_sel_txd, w_sel_rxd, w_sel_con;
  logic w_txd_wr, w_con_wr, w_con_rd, w_rxd_rd;
  logic w_unused_wdata;

  assign w_sel_txd      = (addr == ADDR_TXD);
  assign w_sel_rxd      = (addr == ADDR_RXD);
  assign w_sel_con      = (addr == ADDR_CON);
  assign w_txd_wr       = wr & w_sel_txd;
  assign w_con_wr       = wr & w_sel_con;
  assign w_con_rd       = rd & w_sel_con;
  assign w_rxd_rd       = rd & w_sel_rxd;
  assign w_unused_wdata = ^wdata[31:8];

  // ---------------------------------------------------------------- TX FSM
  tx_state_t        r_tx_state, w_tx_state_n;
  logic [OVS_W-1:0] r_tx_ovs, w_tx_ovs_n;
  logic [2:0]       r_tx_bit, w_tx_bit_n;
  logic [7:0]       r_tx_shift, w_tx_shift_n;
  logic             r_tx_busy, w_tx_busy_n;
  logic [7:0]       r_tx_data;
  logic             r_uart_tx, w_tx_line_n;
  logic             w_tx_accept, w_tx_bit_end, w_tx_done_set;

  assign w_tx_accept  = w_txd_wr & ~r_tx_busy;
  assign w_tx_bit_end = w_tick & (r_tx_ovs == OVS_W'(OVS - 1));

  // TX state register plus registered line output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_ovs   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_data  <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_ovs   <= w_tx_ovs_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx_busy  <= w_tx_busy_n;
      r_uart_tx  <= w_tx_line_n;
      if (w_tx_accept) r_tx_data <= wdata[7:0];
    end
  end

  // TX next-state: an accepted byte waits in IDLE (busy) for the next tick.
  always_comb begin
    w_tx_state_n  = r_tx_state;
    w_tx_ovs_n    = r_tx_ovs;
    w_tx_bit_n    = r_tx_bit;
    w_tx_shift_n  = r_tx_shift;
    w_tx_busy_n   = r_tx_busy;
    w_tx_done_set = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tx_accept) begin
          w_tx_busy_n  = 1'b1;
          w_tx_shift_n = wdata[7:0];
        end else if (r_tx_busy && w_tick) begin
          w_tx_state_n = TX_START;
          w_tx_ovs_n   = '0;
        end
      end
      TX_START: begin
        if (w_tick) w_tx_ovs_n = r_tx_ovs + 1'b1;
        if (w_tx_bit_end) begin
          w_tx_ovs_n   = '0;
          w_tx_bit_n   = '0;
          w_tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_tick) w_tx_ovs_n = r_tx_ovs + 1'b1;
        if (w_tx_bit_end) begin
          w_tx_ovs_n = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_n = TX_STOP;
          end else begin
            w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_n   = r_tx_bit + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (w_tick) w_tx_ovs_n = r_tx_ovs + 1'b1;
        if (w_tx_bit_end) begin
          w_tx_ovs_n    = '0;
          w_tx_state_n  = TX_IDLE;
          w_tx_busy_n   = 1'b0;
          w_tx_done_set = 1'b1;
        end
      end
      default: w_tx_state_n = TX_IDLE;
    endcase
    case (w_tx_state_n)
      TX_START: w_tx_line_n = 1'b0;
      TX_DATA:  w_tx_line_n = w_tx_shift_n[0];
      default:  w_tx_line_n = 1'b1;
    endcase
  end

  assign uart_tx = r_uart_tx;

  // ---------------------------------------------------------------- RX path
  logic [1:0]       r_rx_sync;
  logic             r_rx_prev;
  logic             w_rx_line, w_rx_fall;
  rx_state_t        r_rx_state, w_rx_state_n;
  logic [OVS_W-1:0] r_rx_ovs, w_rx_ovs_n;
  logic [2:0]       r_rx_bit, w_rx_bit_n;
  logic [7:0]       r_rx_shift, w_rx_shift_n;
  logic             w_rx_half, w_rx_full, w_rx_push, w_ferr_set;

  assign w_rx_line = r_rx_sync[1];
  assign w_rx_fall = r_rx_prev & ~w_rx_line;
  assign w_rx_half = w_tick & (r_rx_ovs == OVS_W'(OVS / 2 - 1));
  assign w_rx_full = w_tick & (r_rx_ovs == OVS_W'(OVS - 1));

  // Two-flop synchroniser on the asynchronous line, plus edge history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], uart_rx};
      r_rx_prev <= w_rx_line;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_ovs   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_ovs   <= w_rx_ovs_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
    end
  end

  // RX next-state: half-bit check rejects glitches, then mid-bit sampling.
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_ovs_n   = r_rx_ovs;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_push    = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_n = RX_START;
          w_rx_ovs_n   = '0;
        end
      end
      RX_START: begin
        if (w_tick) w_rx_ovs_n = r_rx_ovs + 1'b1;
        if (w_rx_half) begin
          w_rx_ovs_n = '0;
          w_rx_bit_n = '0;
          w_rx_state_n = w_rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_tick) w_rx_ovs_n = r_rx_ovs + 1'b1;
        if (w_rx_full) begin
          w_rx_ovs_n   = '0;
          w_rx_shift_n = {w_rx_line, r_rx_shift[7:1]};
          w_rx_bit_n   = r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_tick) w_rx_ovs_n = r_rx_ovs + 1'b1;
        if (w_rx_full) begin
          w_rx_ovs_n   = '0;
          w_rx_push    = w_rx_line;
          w_ferr_set   = ~w_rx_line;
          w_rx_state_n = RX_IDLE;
        end
      end
      default: w_rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0] w_fifo_head;
  logic       w_fifo_full, w_fifo_empty, w_fifo_pop, w_ovr_set;

  assign w_fifo_pop = w_rxd_rd & ~w_fifo_empty;
  assign w_ovr_set  = w_rx_push & w_fifo_full & ~w_fifo_pop;

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (w_fifo_pop),
    .din   (r_rx_shift),
    .head  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------- CON / irq
  logic               r_tx_ie, r_rx_ie, r_tx_done, r_rx_ovr, r_frame_err, r_irq;
  logic [CON_W-1:0]   w_con;

  // Enables are CPU-writable; sticky flags clear on CON read, set wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_ie     <= 1'b0;
      r_rx_ie     <= 1'b0;
      r_tx_done   <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_con_wr) begin
        r_tx_ie <= wdata[CON_TX_IE];
        r_rx_ie <= wdata[CON_RX_IE];
      end
      r_tx_done   <= w_tx_done_set | (r_tx_done   & ~w_con_rd);
      r_rx_ovr    <= w_ovr_set     | (r_rx_ovr    & ~w_con_rd);
      r_frame_err <= w_ferr_set    | (r_frame_err & ~w_con_rd);
    end
  end

  // Level interrupt, registered one cycle behind its cause.
  always_ff @(posedge clk) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= (r_tx_ie & r_tx_done) | (r_rx_ie & ~w_fifo_empty);
  end

  assign irq = r_irq;

  always_comb begin
    w_con                = '0;
    w_con[CON_TX_IE]     = r_tx_ie;
    w_con[CON_RX_IE]     = r_rx_ie;
    w_con[CON_TX_DONE]   = r_tx_done;
    w_con[CON_RX_AVAIL]  = ~w_fifo_empty;
    w_con[CON_TX_BUSY]   = r_tx_busy;
    w_con[CON_RX_OVR]    = r_rx_ovr;
    w_con[CON_FRAME_ERR] = r_frame_err;
  end

  // Read mux: zero unless a mapped register is read.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (w_sel_txd)      rdata[7:0]       = r_tx_data;
      else if (w_sel_rxd) rdata[7:0]       = w_fifo_empty ? 8'h00 : w_fifo_head;
      else if (w_sel_con) rdata[CON_W-1:0] = w_con;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_port
// Description : Self-checking bench for uart_bus_port. A reduced clock rate
//               keeps frames short; a behavioural model (frame bit lists, a
//               byte queue for the RX FIFO, flag variables) predicts results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_port;

  localparam int CLK_HZ   = 700_000;              // DIV truncates 4.557 -> 4
  localparam int BAUD     = 9600;
  localparam int OVS      = 16;
  localparam int RX_DEPTH = 4;
  localparam int DIV      = CLK_HZ / (BAUD * OVS);
  localparam int BITCLK   = DIV * OVS;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] rxq[$];
  logic       m_tx_ie, m_rx_ie, m_done, m_ovr, m_ferr;

  uart_bus_port #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .OVS      (OVS),
    .RX_DEPTH (RX_DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] con_exp();
    return {25'd0, m_ferr, m_ovr, 1'b0, (rxq.size() != 0), m_done, m_rx_ie, m_tx_ie};
  endfunction

  task automatic model_reset();
    rxq.delete();
    m_tx_ie = 0; m_rx_ie = 0; m_done = 0; m_ovr = 0; m_ferr = 0;
  endtask

  // All bus tasks start and end on a falling clock edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0; addr = '0;
  endtask

  task automatic con_write(input logic tx_ie, input logic rx_ie);
    bus_write(A_CON, {30'd0, rx_ie, tx_ie});
    m_tx_ie = tx_ie; m_rx_ie = rx_ie;
  endtask

  task automatic con_check(input string tag);
    logic [31:0] v, e;
    e = con_exp();
    bus_read(A_CON, v);
    check(tag, v, e);
    m_done = 0; m_ovr = 0; m_ferr = 0;
  endtask

  task automatic rxd_check(input string tag);
    logic [31:0] v, e;
    e = (rxq.size() != 0) ? {24'd0, rxq.pop_front()} : 32'd0;
    bus_read(A_RXD, v);
    check(tag, v, e);
  endtask

  // Drive one 8N1 frame onto uart_rx and update the FIFO model.
  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = f[k];
      repeat (BITCLK) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BITCLK) @(negedge clk);
    if (!stop)                     m_ferr = 1;
    else if (rxq.size() < RX_DEPTH) rxq.push_back(b);
    else                           m_ovr = 1;
  endtask

  // Write TXD and check every clock of the frame against the expected bits.
  task automatic tx_check(input logic [7:0] b, input bit inject, input string tag);
    logic [9:0]  frame;
    int          bad [10];
    int          lat;
    logic [31:0] v;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) bad[k] = 0;
    bus_write(A_TXD, {24'd0, b});
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 4 * DIV) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " start latency ok"}, 32'((lat >= 1) && (lat <= DIV)), 32'd1);
    for (int i = 0; i < 10 * BITCLK; i++) begin
      if (uart_tx !== frame[i / BITCLK]) bad[i / BITCLK]++;
      if (inject && i == 2 * BITCLK) begin
        wr = 1'b1; addr = A_TXD; wdata = 32'h0000_003C;
      end
      if (i == 2 * BITCLK + 1) begin
        wr = 1'b0; addr = '0; wdata = '0;
      end
      if (i == 5 * BITCLK) begin
        rd = 1'b1; addr = A_CON;
        #1 v = rdata;
        check({tag, " CON busy mid-frame"}, {31'd0, v[4]}, 32'd1);
        m_done = 0; m_ovr = 0; m_ferr = 0;
      end
      if (i == 5 * BITCLK + 1) begin
        rd = 1'b0; addr = '0;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++)
      check($sformatf("%s bit%0d bad clocks", tag, k), 32'(bad[k]), 32'd0);
    m_done = 1;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    model_reset();

    // ---- reset and idle
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset irq", {31'd0, irq}, 32'd0);
    con_check("reset CON");
    rxd_check("reset RXD empty");
    bus_read(32'h4000_0024, v);
    check("unmapped read", v, 32'd0);
    addr = A_CON; #1;
    check("rd low rdata", rdata, 32'd0);
    @(negedge clk); addr = '0;

    // ---- TX 0xA5 with an ignored second write while busy
    tx_check(8'hA5, 1'b1, "txA5");
    repeat (2) @(negedge clk);
    con_check("txA5 CON done");
    con_check("txA5 CON cleared");
    bus_read(A_TXD, v);
    check("TXD keeps A5", v, 32'hA5);

    // ---- random TX bytes with tx interrupt enabled
    con_write(1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      b = 8'($urandom_range(0, 255));
      tx_check(b, 1'b0, $sformatf("tx%02h", b));
      @(negedge clk);
      check("tx irq set", {31'd0, irq}, 32'd1);
      con_check("tx CON done+ie");
      @(negedge clk);
      check("tx irq cleared", {31'd0, irq}, 32'd0);
    end

    // ---- RX 0x5A with rx interrupt
    con_write(1'b0, 1'b1);
    uart_send(8'h5A, 1'b1);
    check("rx irq set", {31'd0, irq}, 32'd1);
    con_check("rx CON avail");
    rxd_check("rx RXD 5A");
    con_check("rx CON after pop");
    check("rx irq cleared", {31'd0, irq}, 32'd0);

    // ---- random RX bytes
    for (int n = 0; n < 2; n++) begin
      uart_send(8'($urandom_range(0, 255)), 1'b1);
      rxd_check("rx random byte");
    end

    // ---- overrun: five bytes, no reads
    for (int n = 1; n <= 5; n++) uart_send(8'(n), 1'b1);
    con_check("overrun CON");
    uart_send(8'h77, 1'b0);
    con_check("frame error CON");
    for (int n = 0; n < RX_DEPTH; n++) rxd_check("drain FIFO");
    rxd_check("drained RXD empty");
    con_check("drained CON");

    // ---- glitch rejection: low for 3 ticks
    uart_rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    con_check("glitch CON");
    rxd_check("glitch RXD empty");

    // ---- reset mid-TX with a byte pending in the FIFO
    uart_send(8'hC3, 1'b1);
    bus_write(A_TXD, 32'h0000_0000);
    repeat (3 * BITCLK) @(negedge clk);
    check("midTX line low", {31'd0, uart_tx}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midTX reset uart_tx", {31'd0, uart_tx}, 32'd1);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("midTX reset irq", {31'd0, irq}, 32'd0);
    con_check("midTX reset CON");
    rxd_check("midTX reset RXD");
    repeat (12 * BITCLK) @(negedge clk);
    check("midTX line idle", {31'd0, uart_tx}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
